// File: rtl/fft_cmul_sequencer_pkg.sv
// Shared fp16 constants, W8 twiddle table and phase/state encodings for the 8-point FFT
// complex-multiply sequencer and later FFT stages.
package fft_cmul_sequencer_pkg;

    localparam logic [15:0] FP16_ZERO          = 16'h0000;
    localparam logic [15:0] FP16_ONE           = 16'h3c00;
    localparam logic [15:0] FP16_NEG_ONE       = 16'hbc00;
    localparam logic [15:0] FP16_HALFROOT2     = 16'h39a8;
    localparam logic [15:0] FP16_NEG_HALFROOT2 = 16'hb9a8;

    localparam logic [1:0] PH_RR = 2'd0;
    localparam logic [1:0] PH_II = 2'd1;
    localparam logic [1:0] PH_RI = 2'd2;
    localparam logic [1:0] PH_IR = 2'd3;

    typedef enum logic {
        ST_IDLE,
        ST_ISSUE
    } state_t;

    // {wr, wi} of W8^k = exp(-j*pi*k/4)
    function automatic logic [31:0] w8_twiddle(input logic [1:0] k);
        logic [31:0] w;
        case (k)
            2'd0:    w = {FP16_ONE, FP16_ZERO};
            2'd1:    w = {FP16_HALFROOT2, FP16_NEG_HALFROOT2};
            2'd2:    w = {FP16_ZERO, FP16_NEG_ONE};
            default: w = {FP16_NEG_HALFROOT2, FP16_NEG_HALFROOT2};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/fft_twiddle_rom_w8.sv
// Combinational W8^k twiddle lookup (k -> fp16 {wr, wi}), shared by the FFT stages.
module fft_twiddle_rom_w8
    import fft_cmul_sequencer_pkg::*;
(
    input  logic [1:0]  i_k,
    output logic [15:0] o_wr,
    output logic [15:0] o_wi
);

    assign {o_wr, o_wi} = w8_twiddle(i_k);

endmodule

// File: rtl/fft_cmul_sequencer.sv
// Feeds the four real products of sample*W8^k to an external fp16 multiplier and regathers them
// into one bundle. Define TRIVIAL_TWIDDLE_BYPASS_EN to route k==0 samples around the multiplier.
module fft_cmul_sequencer
    import fft_cmul_sequencer_pkg::*;
#(
    parameter int MULT_LATENCY = 1,
    parameter int TAG_W        = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [15:0]      i_in_re,
    input  logic [15:0]      i_in_im,
    input  logic [1:0]       i_in_k,
    input  logic [TAG_W-1:0] i_in_tag,
    output logic [15:0]      o_mul_a,
    output logic [15:0]      o_mul_b,
    input  logic [15:0]      i_mul_result,
    input  logic             i_mul_exc,
    output logic             o_out_valid,
    output logic [15:0]      o_out_p_rr,
    output logic [15:0]      o_out_p_ii,
    output logic [15:0]      o_out_p_ri,
    output logic [15:0]      o_out_p_ir,
    output logic [TAG_W-1:0] o_out_tag,
    output logic             o_out_exc
);

    localparam int LAST = MULT_LATENCY;

    state_t           r_state;
    state_t           w_state_next;
    logic [1:0]       r_phase;
    logic [1:0]       w_phase_next;
    logic             w_accept;
    logic             w_is_bypass;
    logic             w_issue;
    logic [15:0]      r_re;
    logic [15:0]      r_im;
    logic [1:0]       r_k;
    logic [TAG_W-1:0] r_tag;
    logic             r_byp_pend;
    logic [15:0]      w_wr;
    logic [15:0]      w_wi;
    logic [15:0]      w_op_a;
    logic [15:0]      w_op_b;

    // Entry i is aligned with the operands registered i cycles earlier; entry LAST meets mul_result.
    logic             r_pipe_valid  [0:LAST];
    logic [1:0]       r_pipe_phase  [0:LAST];
    logic             r_pipe_bypass [0:LAST];
    logic [TAG_W-1:0] r_pipe_tag    [0:LAST];
    logic [15:0]      r_pipe_re     [0:LAST];
    logic [15:0]      r_pipe_im     [0:LAST];

    logic [15:0]      r_slot_rr;
    logic [15:0]      r_slot_ii;
    logic [15:0]      r_slot_ri;
    logic             r_exc_sticky;

    assign w_accept = i_in_valid && o_in_ready;

`ifdef TRIVIAL_TWIDDLE_BYPASS_EN
    assign w_is_bypass = (i_in_k == 2'd0);
`else
    assign w_is_bypass = 1'b0;
`endif

    fft_twiddle_rom_w8 u_twiddle_rom (
        .i_k  (r_k),
        .o_wr (w_wr),
        .o_wi (w_wi)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_phase <= PH_RR;
        end else begin
            r_state <= w_state_next;
            r_phase <= w_phase_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_phase_next = r_phase;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && !w_is_bypass) begin
                    w_state_next = ST_ISSUE;
                    w_phase_next = PH_RR;
                end
            end
            ST_ISSUE: begin
                if (r_phase != PH_IR) begin
                    w_phase_next = r_phase + 2'd1;
                end else if (w_accept && !w_is_bypass) begin
                    w_phase_next = PH_RR;
                end else begin
                    w_state_next = ST_IDLE;
                    w_phase_next = PH_RR;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_phase_next = PH_RR;
            end
        endcase
    end

    // The last issue phase doubles as an accept slot so consecutive samples issue without a gap.
    always_comb begin
        o_in_ready = 1'b0;
        w_issue    = 1'b0;
        case (r_state)
            ST_IDLE:  o_in_ready = 1'b1;
            ST_ISSUE: begin
                w_issue    = 1'b1;
                o_in_ready = (r_phase == PH_IR);
            end
            default: ;
        endcase
    end

    always_comb begin
        w_op_a = r_re;
        w_op_b = w_wr;
        case (r_phase)
            PH_II: begin
                w_op_a = r_im;
                w_op_b = w_wi;
            end
            PH_RI: begin
                w_op_a = r_re;
                w_op_b = w_wi;
            end
            PH_IR: begin
                w_op_a = r_im;
                w_op_b = w_wr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_re  <= '0;
            r_im  <= '0;
            r_k   <= '0;
            r_tag <= '0;
        end else if (w_accept) begin
            r_re  <= i_in_re;
            r_im  <= i_in_im;
            r_k   <= i_in_k;
            r_tag <= i_in_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byp_pend <= 1'b0;
            o_mul_a    <= '0;
            o_mul_b    <= '0;
            for (int i = 0; i <= LAST; i++) begin
                r_pipe_valid[i]  <= 1'b0;
                r_pipe_phase[i]  <= PH_RR;
                r_pipe_bypass[i] <= 1'b0;
                r_pipe_tag[i]    <= '0;
                r_pipe_re[i]     <= '0;
                r_pipe_im[i]     <= '0;
            end
        end else begin
            r_byp_pend       <= w_accept && w_is_bypass;
            o_mul_a          <= w_issue ? w_op_a : '0;
            o_mul_b          <= w_issue ? w_op_b : '0;
            r_pipe_valid[0]  <= w_issue || r_byp_pend;
            r_pipe_phase[0]  <= r_phase;
            r_pipe_bypass[0] <= r_byp_pend;
            r_pipe_tag[0]    <= r_tag;
            r_pipe_re[0]     <= r_re;
            r_pipe_im[0]     <= r_im;
            for (int i = 1; i <= LAST; i++) begin
                r_pipe_valid[i]  <= r_pipe_valid[i-1];
                r_pipe_phase[i]  <= r_pipe_phase[i-1];
                r_pipe_bypass[i] <= r_pipe_bypass[i-1];
                r_pipe_tag[i]    <= r_pipe_tag[i-1];
                r_pipe_re[i]     <= r_pipe_re[i-1];
                r_pipe_im[i]     <= r_pipe_im[i-1];
            end
        end
    end

    // The IR product goes straight from mul_result into the bundle, so it never needs a slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_rr    <= '0;
            r_slot_ii    <= '0;
            r_slot_ri    <= '0;
            r_exc_sticky <= 1'b0;
            o_out_valid  <= 1'b0;
            o_out_p_rr   <= '0;
            o_out_p_ii   <= '0;
            o_out_p_ri   <= '0;
            o_out_p_ir   <= '0;
            o_out_tag    <= '0;
            o_out_exc    <= 1'b0;
        end else begin
            o_out_valid <= 1'b0;
            if (r_pipe_valid[LAST]) begin
                if (r_pipe_bypass[LAST]) begin
                    o_out_valid <= 1'b1;
                    o_out_p_rr  <= r_pipe_re[LAST];
                    o_out_p_ii  <= FP16_ZERO;
                    o_out_p_ri  <= FP16_ZERO;
                    o_out_p_ir  <= r_pipe_im[LAST];
                    o_out_tag   <= r_pipe_tag[LAST];
                    o_out_exc   <= 1'b0;
                end else begin
                    case (r_pipe_phase[LAST])
                        PH_RR: begin
                            r_slot_rr    <= i_mul_result;
                            r_exc_sticky <= i_mul_exc;
                        end
                        PH_II: begin
                            r_slot_ii    <= i_mul_result;
                            r_exc_sticky <= r_exc_sticky | i_mul_exc;
                        end
                        PH_RI: begin
                            r_slot_ri    <= i_mul_result;
                            r_exc_sticky <= r_exc_sticky | i_mul_exc;
                        end
                        default: begin
                            o_out_valid  <= 1'b1;
                            o_out_p_rr   <= r_slot_rr;
                            o_out_p_ii   <= r_slot_ii;
                            o_out_p_ri   <= r_slot_ri;
                            o_out_p_ir   <= i_mul_result;
                            o_out_tag    <= r_pipe_tag[LAST];
                            o_out_exc    <= r_exc_sticky | i_mul_exc;
                            r_exc_sticky <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_cmul_sequencer.sv
// Self-checking bench for fft_cmul_sequencer; a deterministic stand-in multiplier (latency 1)
// makes every product traceable to its operand pair. Honours TRIVIAL_TWIDDLE_BYPASS_EN.
`timescale 1ns/1ps
module tb_fft_cmul_sequencer;

    localparam int TAG_W = 3;
`ifdef TRIVIAL_TWIDDLE_BYPASS_EN
    localparam bit BYPASS_BUILD = 1'b1;
`else
    localparam bit BYPASS_BUILD = 1'b0;
`endif

    typedef struct packed {
        logic [15:0]      rr;
        logic [15:0]      ii;
        logic [15:0]      ri;
        logic [15:0]      ir;
        logic [TAG_W-1:0] tag;
        logic             exc;
    } bundle_t;

    logic             clk = 1'b0;
    logic             rstN = 1'b0;
    logic             inValid = 1'b0;
    logic             inReady;
    logic [15:0]      inRe = '0;
    logic [15:0]      inIm = '0;
    logic [1:0]       inK = '0;
    logic [TAG_W-1:0] inTag = '0;
    logic [15:0]      mulA;
    logic [15:0]      mulB;
    logic [15:0]      mulResult = '0;
    logic             mulExc = 1'b0;
    logic             outValid;
    logic [15:0]      pRr;
    logic [15:0]      pIi;
    logic [15:0]      pRi;
    logic [15:0]      pIr;
    logic [TAG_W-1:0] outTag;
    logic             outExc;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bundle_t expQ[$];
    int      expCyc[$];
    bundle_t obsQ[$];
    int      obsCyc[$];

    logic [15:0] wrTab [4] = '{16'h3c00, 16'h39a8, 16'h0000, 16'hb9a8};
    logic [15:0] wiTab [4] = '{16'h0000, 16'hb9a8, 16'hbc00, 16'hb9a8};

    fft_cmul_sequencer #(
        .MULT_LATENCY (1),
        .TAG_W        (TAG_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rstN),
        .i_in_valid   (inValid),
        .o_in_ready   (inReady),
        .i_in_re      (inRe),
        .i_in_im      (inIm),
        .i_in_k       (inK),
        .i_in_tag     (inTag),
        .o_mul_a      (mulA),
        .o_mul_b      (mulB),
        .i_mul_result (mulResult),
        .i_mul_exc    (mulExc),
        .o_out_valid  (outValid),
        .o_out_p_rr   (pRr),
        .o_out_p_ii   (pIi),
        .o_out_p_ri   (pRi),
        .o_out_p_ir   (pIr),
        .o_out_tag    (outTag),
        .o_out_exc    (outExc)
    );

    // Free-running clock and a count of rising edges seen so far
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Non-commutative stand-in product, so swapped or misrouted operands show up in the result
    function automatic logic [15:0] mulModel(input logic [15:0] a, input logic [15:0] b);
        return (a ^ {b[10:0], b[15:11]}) + 16'h1357;
    endfunction

    function automatic logic excModel(input logic [15:0] a, input logic [15:0] b);
        return (a[14:10] == 5'h1f) || (b[14:10] == 5'h1f);
    endfunction

    // Stand-in multiplier with one cycle of latency
    always @(posedge clk) begin
        mulResult <= mulModel(mulA, mulB);
        mulExc    <= excModel(mulA, mulB);
    end

    // Logs every bundle pulse with the edge count it appeared after
    always @(negedge clk) begin
        if (outValid) begin
            obsQ.push_back({pRr, pIi, pRi, pIr, outTag, outExc});
            obsCyc.push_back(cyc);
        end
    end

    // Reference result of sample * W8^k, straight from the complex-product definition
    function automatic bundle_t modelBundle(input logic [15:0] re, input logic [15:0] im,
                                            input logic [1:0] k, input logic [TAG_W-1:0] tag);
        bundle_t b;
        logic [15:0] wr;
        logic [15:0] wi;
        wr = wrTab[k];
        wi = wiTab[k];
        b.tag = tag;
        if (BYPASS_BUILD && k == 2'd0) begin
            b.rr  = re;
            b.ii  = 16'h0000;
            b.ri  = 16'h0000;
            b.ir  = im;
            b.exc = 1'b0;
        end else begin
            b.rr  = mulModel(re, wr);
            b.ii  = mulModel(im, wi);
            b.ri  = mulModel(re, wi);
            b.ir  = mulModel(im, wr);
            b.exc = excModel(re, wr) | excModel(im, wi) | excModel(re, wi) | excModel(im, wr);
        end
        return b;
    endfunction

    // Offers one sample, holding in_valid until it is accepted; e0 is the accepting edge number
    task automatic applyStimulus(input logic [15:0] re, input logic [15:0] im, input logic [1:0] k,
                                 input logic [TAG_W-1:0] tag, output int e0);
        bit done;
        done = 1'b0;
        e0   = -1;
        for (int w = 0; w < 40 && !done; w++) begin
            @(negedge clk);
            inValid = 1'b1;
            inRe    = re;
            inIm    = im;
            inK     = k;
            inTag   = tag;
            if (inReady === 1'b1) begin
                done = 1'b1;
                e0   = cyc + 1;
                expQ.push_back(modelBundle(re, im, k, tag));
                expCyc.push_back(e0 + ((BYPASS_BUILD && k == 2'd0) ? 3 : 6));
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL accept_timeout: in_ready stayed low for tag %0d, required a handshake", tag);
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            inValid = 1'b0;
        end
    endtask

    // Waits for all expected bundles, then compares contents, order and timing, and the held fields
    task automatic checkOutput(input string name);
        int      n;
        bundle_t e;
        bundle_t o;
        bundle_t last;
        bit      haveLast;
        int      ec;
        int      oc;
        haveLast = 1'b0;
        last     = '0;
        n        = expQ.size();
        for (int w = 0; w < 100 && obsQ.size() < n; w++) @(negedge clk);
        idleCycles(8);
        checks++;
        if (obsQ.size() != n) begin
            errors++;
            $display("[TB] FAIL %s_count: got %0d bundles, required %0d", name, obsQ.size(), n);
        end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e  = expQ.pop_front();
            o  = obsQ.pop_front();
            ec = expCyc.pop_front();
            oc = obsCyc.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL %s_bundle: got %h, required %h", name, o, e);
            end
            checks++;
            if (oc != ec) begin
                errors++;
                $display("[TB] FAIL %s_latency: out_valid after edge %0d, required %0d", name, oc, ec);
            end
            last     = e;
            haveLast = 1'b1;
        end
        if (haveLast) begin
            checks++;
            if ({pRr, pIi, pRi, pIr, outTag, outExc} !== last) begin
                errors++;
                $display("[TB] FAIL %s_hold: fields %h, required %h", name,
                         {pRr, pIi, pRi, pIr, outTag, outExc}, last);
            end
        end
        expQ.delete();
        expCyc.delete();
        obsQ.delete();
        obsCyc.delete();
    endtask

    task automatic test_reset();
        rstN    = 1'b0;
        inValid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({outValid, pRr, pIi, pRi, pIr, outTag, outExc, mulA, mulB} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h, required 0",
                     {outValid, pRr, pIi, pRi, pIr, outTag, outExc, mulA, mulB});
        end
        rstN = 1'b1;
        @(negedge clk);
        checks++;
        if (inReady !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ready: in_ready %b, required 1", inReady);
        end
    endtask

    // Operand order on the multiplier port for a k=1 sample, then zeros once issue ends
    task automatic test_issue_order();
        int e0;
        logic [15:0] expA [5] = '{16'hc200, 16'hbc00, 16'hc200, 16'hbc00, 16'h0000};
        logic [15:0] expB [5] = '{16'h39a8, 16'hb9a8, 16'hb9a8, 16'h39a8, 16'h0000};
        applyStimulus(16'hc200, 16'hbc00, 2'd1, 3'd5, e0);
        @(negedge clk);
        inValid = 1'b0;
        for (int p = 0; p < 5; p++) begin
            @(negedge clk);
            checks++;
            if (mulA !== expA[p] || mulB !== expB[p]) begin
                errors++;
                $display("[TB] FAIL issue_phase%0d: mul_a/mul_b %h/%h, required %h/%h",
                         p, mulA, mulB, expA[p], expB[p]);
            end
        end
        checkOutput("t1");
    endtask

    task automatic test_zero_sign();
        int e0;
        applyStimulus(16'hbc00, 16'h0000, 2'd2, 3'd2, e0);
        idleCycles(1);
        checkOutput("t2");
    endtask

    task automatic test_back_to_back();
        int e0 [3];
        for (int i = 0; i < 3; i++)
            applyStimulus(16'($urandom), 16'($urandom), 2'($urandom_range(1, 3)), 3'(i + 1), e0[i]);
        idleCycles(1);
        for (int i = 1; i < 3; i++) begin
            checks++;
            if (e0[i] - e0[i-1] != 4) begin
                errors++;
                $display("[TB] FAIL b2b_spacing%0d: accepted %0d cycles apart, required 4",
                         i, e0[i] - e0[i-1]);
            end
        end
        checkOutput("t3");
    endtask

    task automatic test_reset_mid_issue();
        int e0;
        applyStimulus(16'h4400, 16'hc000, 2'd3, 3'd6, e0);
        idleCycles(2);
        rstN = 1'b0;
        expQ.delete();
        expCyc.delete();
        #1;
        checks++;
        if ({outValid, pRr, pIi, pRi, pIr, outTag, outExc, mulA, mulB} !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got %h, required 0",
                     {outValid, pRr, pIi, pRi, pIr, outTag, outExc, mulA, mulB});
        end
        idleCycles(2);
        rstN = 1'b1;
        idleCycles(1);
        checks++;
        if (inReady !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_ready: in_ready %b, required 1", inReady);
        end
        idleCycles(12);
        checks++;
        if (obsQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL midreset_ghost: got %0d bundles, required 0", obsQ.size());
        end
        obsQ.delete();
        obsCyc.delete();
        applyStimulus(16'h3800, 16'hb800, 2'd1, 3'd7, e0);
        idleCycles(1);
        checkOutput("t4");
    endtask

    task automatic test_exception();
        int e0;
        applyStimulus(16'h7c00, 16'h3800, 2'd1, 3'd3, e0);
        applyStimulus(16'h3c00, 16'h3800, 2'd1, 3'd4, e0);
        idleCycles(1);
        checkOutput("t5");
    endtask

    task automatic test_random();
        int e0;
        logic [15:0] re;
        for (int i = 0; i < 24; i++) begin
            re = ($urandom_range(0, 7) == 0) ? 16'h7c00 : 16'($urandom);
            applyStimulus(re, 16'($urandom), 2'($urandom), 3'(i), e0);
            idleCycles($urandom_range(0, 3));
        end
        idleCycles(1);
        checkOutput("rand");
    endtask

`ifdef TRIVIAL_TWIDDLE_BYPASS_EN
    task automatic test_bypass();
        int e0 [4];
        applyStimulus(16'hc200, 16'h39a8, 2'd0, 3'd1, e0[0]);
        applyStimulus(16'h4000, 16'hbc00, 2'd0, 3'd2, e0[1]);
        applyStimulus(16'h7c00, 16'h3c00, 2'd0, 3'd3, e0[2]);
        applyStimulus(16'h3c00, 16'h3800, 2'd2, 3'd4, e0[3]);
        idleCycles(1);
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (e0[i] - e0[i-1] != 1) begin
                errors++;
                $display("[TB] FAIL bypass_rate%0d: accepted %0d cycles apart, required 1",
                         i, e0[i] - e0[i-1]);
            end
        end
        checkOutput("t6");
    endtask
`endif

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_issue_order();
        test_zero_sign();
        test_back_to_back();
        test_reset_mid_issue();
        test_exception();
`ifdef TRIVIAL_TWIDDLE_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
